// File: rtl/o_serdes_dly.sv
// ---------------------------------------------------------------------------
// o_serdes_dly
//
// Output serializer with delay-tap control. It turns WIDTH-bit parallel words
// into a 1-bit (SDR) or 2-bit (DDR) per-cycle beat stream for an oddr/obuft
// pair. It also holds the tap value for the downstream IO delay line.
//
// Ports
//   C              clock, all logic on the rising edge
//   R              synchronous active-high reset
//   D              parallel word, bit 0 is transmitted first
//   D_VALID        D holds a word
//   OE             output enable for the word (qualified by D_VALID)
//   D_READY        word accepted when D_VALID & D_READY
//   Q              beat to oddr: Q[0] rising-half bit, Q[1] falling-half bit
//   Q_OE           tristate enable to obuft (OE latched with the current word)
//   UNDERRUN       one-cycle pulse in the first IDLE cycle after a word
//                  ends with no follow-on word
//   DLY_LD         load DELAY into the tap register
//   DLY_ADJ        adjust strobe, acted on at its rising edge
//   DLY_INC        adjust direction, 1 = increment, 0 = decrement
//   DLY_TAP_VALUE  current tap value
// ---------------------------------------------------------------------------
module o_serdes_dly #(
  parameter int WIDTH     = 8,
  parameter     DATA_RATE = "DDR",
  parameter int DLY_TAPS  = 64,
  parameter int DELAY     = 0
) (
  input  logic                        C,
  input  logic                        R,
  input  logic [WIDTH-1:0]            D,
  input  logic                        D_VALID,
  input  logic                        OE,
  output logic                        D_READY,
  output logic [1:0]                  Q,
  output logic                        Q_OE,
  output logic                        UNDERRUN,
  input  logic                        DLY_LD,
  input  logic                        DLY_ADJ,
  input  logic                        DLY_INC,
  output logic [$clog2(DLY_TAPS)-1:0] DLY_TAP_VALUE
);

  localparam int BPC = (DATA_RATE == "DDR") ? 2 : 1;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int TW  = $clog2(DLY_TAPS);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [TW-1:0] TAP_MAX  = TW'(DLY_TAPS - 1);
  localparam logic [TW-1:0] TAP_RST  = TW'(DELAY);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Serializer
  // -------------------------------------------------------------------------
  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             oe_q;
  logic             underrun_q;

  logic last_beat;
  logic accept;

  assign last_beat = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  // Ready on the last beat so the next word loads with no bubble.
  assign D_READY   = (state_q == IDLE) || last_beat;
  assign accept    = D_VALID && D_READY;

  always_ff @(posedge C) begin
    if (R) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      oe_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sr_q    <= D;
            oe_q    <= OE;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_beat) begin
            if (accept) begin
              // Reload wins over underrun: the stream stays gapless.
              sr_q  <= D;
              oe_q  <= OE;
              cnt_q <= '0;
            end else begin
              state_q    <= IDLE;
              oe_q       <= 1'b0;
              underrun_q <= 1'b1;
            end
          end else begin
            sr_q  <= sr_q >> BPC;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Q is decoded from registered state only; IDLE drives zeros so stale
  // shift-register contents never leak out.
  always_comb begin
    Q = 2'b00;
    if (state_q == SHIFT) begin
      if (BPC == 2) Q = sr_q[1:0];
      else          Q = {sr_q[0], sr_q[0]};
    end
  end

  assign Q_OE     = (state_q == SHIFT) && oe_q;
  assign UNDERRUN = underrun_q;

  // -------------------------------------------------------------------------
  // Delay-tap control, independent of the serializer
  // -------------------------------------------------------------------------
  logic [TW-1:0] tap_q, tap_d;
  logic          dly_adj_q;
  logic          adj_ev;

  // Rising edge of the strobe: holding DLY_ADJ high steps only once.
  assign adj_ev = DLY_ADJ && !dly_adj_q;

  always_comb begin
    tap_d = tap_q;
    if (DLY_LD) begin
      tap_d = TAP_RST;
    end else if (adj_ev) begin
      if (DLY_INC) begin
        if (tap_q != TAP_MAX) tap_d = tap_q + 1'b1;
      end else begin
        if (tap_q != '0) tap_d = tap_q - 1'b1;
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      tap_q     <= TAP_RST;
      dly_adj_q <= 1'b0;
    end else begin
      tap_q     <= tap_d;
      dly_adj_q <= DLY_ADJ;
    end
  end

  assign DLY_TAP_VALUE = tap_q;

endmodule

// File: tb/tb_o_serdes_dly.sv
// ---------------------------------------------------------------------------
// tb_o_serdes_dly: directed bench for o_serdes_dly.
//   u_a : WIDTH=8  DDR, DLY_TAPS=64, DELAY=62  (single word, underrun, taps)
//   u_b : WIDTH=4  SDR, DLY_TAPS=16, DELAY=1   (back-to-back, tap floor)
//   u_c : WIDTH=8  SDR, DLY_TAPS=4,  DELAY=0   (reset mid-word)
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_o_serdes_dly;

  logic C = 1'b0;
  always #5 C = ~C;

  int n_tests = 0;
  int n_fail  = 0;

  // u_a
  logic       r_a, v_a, oe_a, rdy_a, qoe_a, un_a, ld_a, adj_a, inc_a;
  logic [7:0] d_a;
  logic [1:0] q_a;
  logic [5:0] tap_a;
  // u_b
  logic       r_b, v_b, oe_b, rdy_b, qoe_b, un_b, ld_b, adj_b, inc_b;
  logic [3:0] d_b;
  logic [1:0] q_b;
  logic [3:0] tap_b;
  // u_c
  logic       r_c, v_c, oe_c, rdy_c, qoe_c, un_c;
  logic [7:0] d_c;
  logic [1:0] q_c;
  logic [1:0] tap_c;

  o_serdes_dly #(.WIDTH(8), .DATA_RATE("DDR"), .DLY_TAPS(64), .DELAY(62)) u_a (
    .C(C), .R(r_a), .D(d_a), .D_VALID(v_a), .OE(oe_a), .D_READY(rdy_a),
    .Q(q_a), .Q_OE(qoe_a), .UNDERRUN(un_a), .DLY_LD(ld_a), .DLY_ADJ(adj_a),
    .DLY_INC(inc_a), .DLY_TAP_VALUE(tap_a));

  o_serdes_dly #(.WIDTH(4), .DATA_RATE("SDR"), .DLY_TAPS(16), .DELAY(1)) u_b (
    .C(C), .R(r_b), .D(d_b), .D_VALID(v_b), .OE(oe_b), .D_READY(rdy_b),
    .Q(q_b), .Q_OE(qoe_b), .UNDERRUN(un_b), .DLY_LD(ld_b), .DLY_ADJ(adj_b),
    .DLY_INC(inc_b), .DLY_TAP_VALUE(tap_b));

  o_serdes_dly #(.WIDTH(8), .DATA_RATE("SDR"), .DLY_TAPS(4), .DELAY(0)) u_c (
    .C(C), .R(r_c), .D(d_c), .D_VALID(v_c), .OE(oe_c), .D_READY(rdy_c),
    .Q(q_c), .Q_OE(qoe_c), .UNDERRUN(un_c), .DLY_LD(1'b0), .DLY_ADJ(1'b0),
    .DLY_INC(1'b0), .DLY_TAP_VALUE(tap_c));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // Q[1:0] per beat (Q[0] = even bit, Q[1] = odd bit of each pair).
  // 8'hB4 = 1011_0100 -> pairs {b1,b0}=00 {b3,b2}=01 {b5,b4}=11 {b7,b6}=10
  logic [1:0] beats_b4 [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  // 8'h1E = 0001_1110 -> 10, 11, 01, 00
  logic [1:0] beats_1e [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  // 4'hA then 4'h5, LSB first
  logic       seq_sdr  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    {r_a, v_a, oe_a, ld_a, adj_a, inc_a} = '0; d_a = '0;
    {r_b, v_b, oe_b, ld_b, adj_b, inc_b} = '0; d_b = '0;
    {r_c, v_c, oe_c} = '0; d_c = '0;

    // ---- reset, 2 cycles ----
    r_a = 1'b1; r_b = 1'b1; r_c = 1'b1;
    tick(); tick();
    chk("rst q",     q_a,   2'b00);
    chk("rst qoe",   qoe_a, 1'b0);
    chk("rst rdy",   rdy_a, 1'b1);
    chk("rst un",    un_a,  1'b0);
    chk("rst tap_a", tap_a, 62);
    chk("rst tap_b", tap_b, 1);
    chk("rst tap_c", tap_c, 0);
    r_a = 1'b0; r_b = 1'b0; r_c = 1'b0;

    // ---- single DDR word 8'hB4, OE=1 ----
    d_a = 8'hB4; v_a = 1'b1; oe_a = 1'b1;
    tick();
    v_a = 1'b0; oe_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b4 q%0d", k),   q_a,   beats_b4[k]);
      chk($sformatf("b4 qoe%0d", k), qoe_a, 1'b1);
      chk($sformatf("b4 rdy%0d", k), rdy_a, (k == 3));
      chk($sformatf("b4 un%0d", k),  un_a,  1'b0);
      tick();
    end
    chk("b4 idle un",  un_a,  1'b1);
    chk("b4 idle q",   q_a,   2'b00);
    chk("b4 idle qoe", qoe_a, 1'b0);
    chk("b4 idle rdy", rdy_a, 1'b1);

    // ---- underrun recovery: word 3 cycles after draining, OE=0 ----
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("gap un%0d", i), un_a, 1'b0);
    end
    d_a = 8'h1E; v_a = 1'b1; oe_a = 1'b0;
    tick();
    v_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("1e q%0d", k),   q_a,   beats_1e[k]);
      chk($sformatf("1e qoe%0d", k), qoe_a, 1'b0);
      chk($sformatf("1e un%0d", k),  un_a,  1'b0);
      tick();
    end
    chk("1e un pulse", un_a, 1'b1);
    tick();
    chk("1e un clear", un_a, 1'b0);

    // ---- back-to-back SDR 4'hA, 4'h5 ----
    d_b = 4'hA; v_b = 1'b1; oe_b = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("sdr q0_%0d", k), q_b[0], seq_sdr[k]);
      chk($sformatf("sdr q1_%0d", k), q_b[1], seq_sdr[k]);
      chk($sformatf("sdr rdy%0d", k), rdy_b,  ((k % 4) == 3));
      chk($sformatf("sdr un%0d", k),  un_b,   1'b0);
      chk($sformatf("sdr qoe%0d", k), qoe_b,  1'b1);
      if (k == 0) d_b = 4'h5;
      if (k == 4) v_b = 1'b0;
      tick();
    end
    chk("sdr end un", un_b, 1'b1);
    chk("sdr end q",  q_b,  2'b00);

    // ---- reset at beat 2 of an 8-beat word ----
    d_c = 8'hFF; v_c = 1'b1; oe_c = 1'b1;
    tick();
    v_c = 1'b0;
    chk("mid q beat0", q_c, 2'b11);
    tick();
    chk("mid q beat1", q_c, 2'b11);
    tick();
    chk("mid q beat2", q_c, 2'b11);
    // word offered during reset must not be taken
    r_c = 1'b1; v_c = 1'b1;
    tick();
    chk("mid rst q",   q_c,   2'b00);
    chk("mid rst qoe", qoe_c, 1'b0);
    chk("mid rst rdy", rdy_c, 1'b1);
    chk("mid rst un",  un_c,  1'b0);
    r_c = 1'b0; v_c = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mid after q%0d", i),  q_c,  2'b00);
      chk($sformatf("mid after un%0d", i), un_c, 1'b0);
    end

    // ---- tap saturation on u_a (starts at 62) ----
    inc_a = 1'b1;
    for (int p = 0; p < 3; p++) begin
      adj_a = 1'b1;
      tick();
      chk($sformatf("tap inc%0d", p), tap_a, 63);
      adj_a = 1'b0;
      tick();
      chk($sformatf("tap hold%0d", p), tap_a, 63);
    end
    ld_a = 1'b1; adj_a = 1'b1;
    tick();
    chk("tap ld wins", tap_a, 62);
    ld_a = 1'b0; adj_a = 1'b0;
    tick();
    chk("tap ld hold", tap_a, 62);
    inc_a = 1'b0; adj_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("tap dec held%0d", i), tap_a, 61);
    end
    adj_a = 1'b0;
    tick();
    chk("tap dec final", tap_a, 61);

    // ---- tap floor on u_b (starts at 1) ----
    inc_b = 1'b0; adj_b = 1'b1;
    tick();
    chk("floor dec1", tap_b, 0);
    adj_b = 1'b0;
    tick();
    adj_b = 1'b1;
    tick();
    chk("floor dec2", tap_b, 0);
    adj_b = 1'b0;
    tick();
    inc_b = 1'b1; adj_b = 1'b1;
    tick();
    chk("floor inc", tap_b, 1);
    adj_b = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
